// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped, one-word-per-line instruction cache between IF and the memory controller
//
// Purpose: serves IF fetches from on-chip storage on a hit (1-cycle latency). On a miss it
// issues a word read to the memory controller, fills the line and returns the instruction.
// A branch flush during a refill lets the fill complete but suppresses the response.
//
// Optional feature macro: ICACHE_PERF_CNT_EN adds hit/miss event counters.
//
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   rdy_in              global ready; low freezes all state and outputs
//   if_req_in, pc_in    IF fetch request (level) and fetch address
//   flush_in            branch mispredict; kill the outstanding fetch
//   inst_valid_out      one-cycle pulse, inst_out valid for the current pc_in
//   inst_out            fetched instruction
//   mem_req_out         word read request, held until mem_done_in
//   mem_addr_out        word-aligned miss address
//   mem_done_in         memory read complete (one-cycle pulse)
//   mem_inst_in         memory read data, valid with mem_done_in
//   hit_cnt_out         (ICACHE_PERF_CNT_EN) hits that produced a pulse
//   miss_cnt_out        (ICACHE_PERF_CNT_EN) IDLE->REFILL transitions
module icache #(
  parameter int INDEX_WIDTH = 7,
  parameter int ADDR_WIDTH  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req_in,
  input  logic [31:0] pc_in,
  input  logic        flush_in,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0] hit_cnt_out,
  output logic [31:0] miss_cnt_out,
`endif
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_done_in,
  input  logic [31:0] mem_inst_in
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - 2 - INDEX_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [INDEX_WIDTH-1:0] fetch_idx, fill_idx;
  logic [TAG_W-1:0]       fetch_tag, fill_tag;
  logic                   hit;
  logic                   fill_we;
  logic                   hit_evt, miss_evt;

  assign fetch_idx = pc_in[INDEX_WIDTH+1:2];
  assign fetch_tag = pc_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
  // The fill uses the latched miss address so it is independent of what IF does with pc_in.
  assign fill_idx  = mem_addr_q[INDEX_WIDTH+1:2];
  assign fill_tag  = mem_addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign hit       = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  // Byte offset and address bits above ADDR_WIDTH do not take part in lookup (aliasing by design).
  logic unused_pc;
  assign unused_pc = ^{pc_in[31:ADDR_WIDTH], pc_in[1:0]};

  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fill_we      = 1'b0;
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // While a hit pulse is on the output IF still holds the old request; skip it.
        if (if_req_in && !flush_in && !inst_valid_q) begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_d       = data_q[fetch_idx];
            hit_evt      = 1'b1;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {pc_in[31:2], 2'b00};
            state_d    = S_REFILL;
            miss_evt   = 1'b1;
          end
        end
      end
      S_REFILL: begin
        if (flush_in) discard_d = 1'b1;
        if (mem_done_in) begin
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
          if (discard_q || flush_in) begin
            discard_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            inst_valid_d = 1'b1;
            inst_d       = mem_inst_in;
            state_d      = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      discard_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      valid_q      <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      if (fill_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Data and tag need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_we) begin
      data_q[fill_idx] <= mem_inst_in;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy_in) begin
      if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_out  = hit_cnt_q;
  assign miss_cnt_out = miss_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = hit_evt ^ miss_evt;
`endif

  assign inst_valid_out = inst_valid_q;
  assign inst_out       = inst_q;
  assign mem_req_out    = mem_req_q;
  assign mem_addr_out   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache against a line-array reference model
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req, flush, mem_done;
  logic [31:0] pc, mem_inst;
  logic        inst_valid, mem_req;
  logic [31:0] inst, mem_addr;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache #(.INDEX_WIDTH(7), .ADDR_WIDTH(18)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .if_req_in     (if_req),
    .pc_in         (pc),
    .flush_in      (flush),
`ifdef ICACHE_PERF_CNT_EN
    .hit_cnt_out   (hit_cnt),
    .miss_cnt_out  (miss_cnt),
`endif
    .inst_valid_out(inst_valid),
    .inst_out      (inst),
    .mem_req_out   (mem_req),
    .mem_addr_out  (mem_addr),
    .mem_done_in   (mem_done),
    .mem_inst_in   (mem_inst)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per line, whether it holds data and which word address it was filled from.
  bit          m_valid [128];
  logic [31:0] m_addr  [128];
  logic [31:0] m_data  [128];
  int          exp_hits = 0;
  int          exp_misses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (wa == 32'h0000_0100) return 32'h00A0_0513;
    return (wa * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % 128);
  endfunction

  // A lookup hits when the line was filled from an address equal in the low 18 bits.
  function automatic bit model_hit(input logic [31:0] a);
    int i = line_of(a);
    return m_valid[i] && (((m_addr[i] ^ a) & 32'h0003_FFFC) == 0);
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int i = line_of(a);
    m_valid[i] = 1'b1;
    m_addr[i]  = a & ~32'h3;
    m_data[i]  = mem_word(a & ~32'h3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, input int lat, input string nm);
    bit h = model_hit(a);
    int i = line_of(a);
    if_req = 1'b1;
    pc     = a;
    step();
    if (h) begin
      exp_hits++;
      chk({nm, " hit valid"}, 32'(inst_valid), 32'd1);
      chk({nm, " hit data"}, inst, m_data[i]);
      chk({nm, " hit no memreq"}, 32'(mem_req), 32'd0);
      if_req = 1'b0;
      step();
      chk({nm, " hit pulse end"}, 32'(inst_valid), 32'd0);
    end else begin
      exp_misses++;
      chk({nm, " miss req"}, 32'(mem_req), 32'd1);
      chk({nm, " miss addr"}, mem_addr, a & ~32'h3);
      chk({nm, " miss no pulse"}, 32'(inst_valid), 32'd0);
      for (int c = 1; c < lat; c++) begin
        step();
        chk({nm, " req held"}, 32'(mem_req), 32'd1);
        chk({nm, " addr held"}, mem_addr, a & ~32'h3);
      end
      mem_done = 1'b1;
      mem_inst = mem_word(a & ~32'h3);
      step();
      mem_done = 1'b0;
      mem_inst = $urandom;
      if_req   = 1'b0;
      chk({nm, " fill valid"}, 32'(inst_valid), 32'd1);
      chk({nm, " fill data"}, inst, mem_word(a & ~32'h3));
      chk({nm, " fill req drop"}, 32'(mem_req), 32'd0);
      model_fill(a);
      step();
      chk({nm, " fill pulse end"}, 32'(inst_valid), 32'd0);
    end
  endtask

  // Miss, then a one-cycle flush flush_at cycles into REFILL (flush_at == lat coincides with done).
  task automatic fetch_flush(input logic [31:0] a, input int lat, input int flush_at, input string nm);
    exp_misses++;
    if_req = 1'b1;
    pc     = a;
    step();
    chk({nm, " req"}, 32'(mem_req), 32'd1);
    for (int c = 1; c <= lat; c++) begin
      if (c == flush_at) begin
        flush  = 1'b1;
        if_req = 1'b0;
      end
      if (c == lat) begin
        mem_done = 1'b1;
        mem_inst = mem_word(a & ~32'h3);
      end
      step();
      flush    = 1'b0;
      mem_done = 1'b0;
      chk({nm, " no pulse"}, 32'(inst_valid), 32'd0);
      chk({nm, " req"}, 32'(mem_req), (c < lat) ? 32'd1 : 32'd0);
    end
    model_fill(a);
    step();
    chk({nm, " still no pulse"}, 32'(inst_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; flush = 1'b0;
    mem_done = 1'b0; pc = '0; mem_inst = '0;
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset valid", 32'(inst_valid), 32'd0);
    chk("reset inst", inst, 32'd0);
    chk("reset memreq", 32'(mem_req), 32'd0);
    chk("reset addr", mem_addr, 32'd0);
    step();
    chk("idle no req", 32'(mem_req), 32'd0);

    // Cold miss, then hit, then conflict misses on the same line
    do_fetch(32'h0000_0100, 4, "s1");
    do_fetch(32'h0000_0100, 1, "s2");
    do_fetch(32'h0000_0300, 3, "s3a");
    do_fetch(32'h0000_0100, 2, "s3b");
`ifdef ICACHE_PERF_CNT_EN
    chk("perf hit", hit_cnt, 32'(exp_hits));
    chk("perf miss", miss_cnt, 32'(exp_misses));
`endif

    // Flush during refill: no pulse, line still filled
    fetch_flush(32'h0000_0104, 4, 2, "s4");
    do_fetch(32'h0000_0104, 1, "s4 refetch");
    fetch_flush(32'h0000_0208, 3, 3, "flush+done");
    do_fetch(32'h0000_0208, 1, "flush+done refetch");

    // Flush in IDLE on a hit suppresses that cycle's pulse only
    if_req = 1'b1; pc = 32'h0000_0104; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("idle flush no pulse", 32'(inst_valid), 32'd0);
    chk("idle flush no req", 32'(mem_req), 32'd0);
    step();
    exp_hits++;
    chk("after idle flush hit", 32'(inst_valid), 32'd1);
    chk("after idle flush data", inst, mem_word(32'h0000_0104));
    if_req = 1'b0;
    step();
    chk("after idle flush end", 32'(inst_valid), 32'd0);

    // rdy_in low mid-refill with mem_done_in asserted: nothing captured
    exp_misses++;
    if_req = 1'b1; pc = 32'h0000_050C;
    step();
    chk("stall req", 32'(mem_req), 32'd1);
    step();
    rdy = 1'b0; mem_done = 1'b1; mem_inst = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall req held", 32'(mem_req), 32'd1);
      chk("stall no pulse", 32'(inst_valid), 32'd0);
    end
    rdy = 1'b1; mem_done = 1'b0;
    step();
    chk("post stall req", 32'(mem_req), 32'd1);
    chk("post stall no pulse", 32'(inst_valid), 32'd0);
    mem_done = 1'b1; mem_inst = mem_word(32'h0000_050C);
    step();
    mem_done = 1'b0; if_req = 1'b0;
    chk("stall fill valid", 32'(inst_valid), 32'd1);
    chk("stall fill data", inst, mem_word(32'h0000_050C));
    model_fill(32'h0000_050C);
    step();
    chk("stall pulse end", 32'(inst_valid), 32'd0);
    do_fetch(32'h0000_050C, 1, "stall refetch");

    // Bits above ADDR_WIDTH are not compared
    do_fetch(32'h0004_0100, 2, "alias");

    // Random fetches over a small set of lines and tags to mix hits and conflicts
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int lat;
      a   = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      lat = $urandom_range(1, 5);
      if (!model_hit(a) && ($urandom_range(0, 3) == 0))
        fetch_flush(a, lat, $urandom_range(1, lat), "rand flush");
      else
        do_fetch(a, lat, "rand");
    end

`ifdef ICACHE_PERF_CNT_EN
    chk("perf hit final", hit_cnt, 32'(exp_hits));
    chk("perf miss final", miss_cnt, 32'(exp_misses));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
